// File: rtl/uart_tx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_if
//  Description : Byte valid/ready handshake between a producer and the
//                UART transmitter FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : 8N1 serial transmitter (LSB first, idle-high line) fed by a
//                small byte FIFO; queued bytes go out back-to-back.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_fifo_if.slave                 tx_if,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int              c_AW       = $clog2(FIFO_DEPTH);
    localparam int              c_CW       = c_AW + 1;
    localparam logic [7:0]      c_CNT_MAX  = 8'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;

    logic [1:0]      r_state;
    logic [7:0]      r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_pin;

    logic [1:0]      w_state_next;
    logic [7:0]      w_cnt_next;
    logic [2:0]      w_bit_next;
    logic [7:0]      w_shift_next;
    logic            w_pin_next;
    logic            w_push;
    logic            w_pop;
    logic            w_cnt_last;
    logic            w_not_full;
    logic            w_not_empty;

    assign w_not_full   = (r_count != c_FULL);
    assign w_not_empty  = (r_count != '0);
    assign w_push       = tx_if.tx_valid && w_not_full;
    assign w_cnt_last   = (r_cnt == c_CNT_MAX);

    assign tx_if.tx_ready = w_not_full;
    assign tx_pin         = r_pin;
    assign tx_busy        = (r_state != c_IDLE);
    assign fifo_count     = r_count;

    // FIFO storage write; contents need no reset since the count gates reads
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer: next state, counters, shift register and FIFO pop
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_cnt_next = 8'd0;
                w_bit_next = 3'd0;
                if (w_not_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = r_mem[r_rd_ptr];
                    w_state_next = c_START;
                end
            end
            c_START: begin
                if (w_cnt_last) begin
                    w_cnt_next   = 8'd0;
                    w_bit_next   = 3'd0;
                    w_state_next = c_DATA;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            c_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_next   = 8'd0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_next = c_STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            c_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_next = 8'd0;
                    w_bit_next = 3'd0;
                    // Chain straight into the next start bit when data waits
                    if (w_not_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = r_mem[r_rd_ptr];
                        w_state_next = c_START;
                    end else begin
                        w_state_next = c_IDLE;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // Line level for the upcoming state, so the flopped pin tracks the state
    always_comb begin
        w_pin_next = 1'b1;
        case (w_state_next)
            c_START: w_pin_next = 1'b0;
            c_DATA:  w_pin_next = w_shift_next[0];
            default: w_pin_next = 1'b1;
        endcase
    end

    // State, counters and the glitch-free line flop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_pin   <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_pin   <= w_pin_next;
        end
    end

endmodule
`default_nettype wire
